// File: rtl/cam_frame_capture_pkg.sv
// Shared definitions for the camera capture engine: pixel format codes,
// RGB332 colour constants and capture FSM state encodings.
package cam_frame_capture_pkg;

  localparam logic [1:0] FMT_RGB565 = 2'b00;
  localparam logic [1:0] FMT_RGB555 = 2'b01;
  localparam logic [1:0] FMT_RGB444 = 2'b10;
  localparam logic [1:0] FMT_YUYV   = 2'b11;

  localparam logic [7:0] RGB332_BLACK = 8'h00;
  localparam logic [7:0] RGB332_RED   = 8'hE0;
  localparam logic [7:0] RGB332_GREEN = 8'h1C;
  localparam logic [7:0] RGB332_BLUE  = 8'h03;
  localparam logic [7:0] RGB332_WHITE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_VS     = 3'd1,
    ST_WAIT_VS_LOW = 3'd2,
    ST_FRAME       = 3'd3,
    ST_DONE        = 3'd4
  } cap_state_e;

endpackage

// File: rtl/cam_pix_convert.sv
// Combinational byte-pair to 8-bit pixel conversion: RGB565/555/444 are
// truncated to RGB332, YUYV keeps only the Y byte.
module cam_pix_convert
  import cam_frame_capture_pkg::*;
(
  input  logic [1:0] fmt_i,
  input  logic [7:0] b0_i,
  input  logic [7:0] b1_i,
  output logic [7:0] pix_o
);

  // b1[1:0] carry only low-order blue/green bits that RGB332 discards
  logic unused_b1;
  assign unused_b1 = ^b1_i[1:0];

  always_comb begin
    pix_o = RGB332_BLACK;
    unique case (fmt_i)
      FMT_RGB565: pix_o = {b0_i[7:5], b0_i[2:0], b1_i[4:3]};
      FMT_RGB555: pix_o = {b0_i[6:4], b0_i[1:0], b1_i[7], b1_i[4:3]};
      FMT_RGB444: pix_o = {b0_i[3:1], b1_i[7:5], b1_i[3:2]};
      FMT_YUYV:   pix_o = b0_i;
      default:    pix_o = RGB332_BLACK;
    endcase
  end

endmodule

// File: rtl/cam_frame_capture.sv
// OV7670 capture engine: frame/line sync decode, byte pairing, format
// conversion and linear frame-buffer writes with status flags.
module cam_frame_capture
  import cam_frame_capture_pkg::*;
#(
  parameter int IMG_W  = 176,
  parameter int IMG_H  = 144,
  parameter int ADDR_W = 15,
  parameter int FCNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [7:0]        cam_data_i,
  input  logic [1:0]        fmt_i,
  input  logic              cont_i,
  input  logic              arm_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [FCNT_W-1:0] frame_cnt_o,
  output logic              line_ovf_o,
  output logic              frame_ovf_o
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int LW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0]     X_MAX  = XW'(IMG_W);
  localparam logic [LW-1:0]     L_MAX  = LW'(IMG_H);
  localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(IMG_W);

  cap_state_e state_q, state_d;

  logic              vs_q, vs_qq, hr_q, hr_qq;
  logic [7:0]        dat_q, b0_q, pix;
  logic [1:0]        fmt_q;
  logic              phase_q, has_data_q;
  logic [XW-1:0]     x_q;
  logic [LW-1:0]     line_q;
  logic [ADDR_W-1:0] addr_q, base_q, wr_addr_q;
  logic              wr_en_q, line_ovf_q, frame_ovf_q;
  logic [7:0]        wr_data_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              vs_rise, vs_fall, hr_fall, pix_en;

  assign vs_rise = vs_q & ~vs_qq;
  assign vs_fall = ~vs_q & vs_qq;
  assign hr_fall = ~hr_q & hr_qq;
  // A byte that coincides with the frame-ending VSYNC edge is not processed
  assign pix_en  = (state_q == ST_FRAME) & hr_q & ~vs_rise;

  cam_pix_convert u_conv (
    .fmt_i (fmt_q),
    .b0_i  (b0_q),
    .b1_i  (dat_q),
    .pix_o (pix)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      hr_q  <= 1'b0;
      hr_qq <= 1'b0;
      dat_q <= '0;
    end else begin
      vs_q  <= vsync_i;
      vs_qq <= vs_q;
      hr_q  <= href_i;
      hr_qq <= hr_q;
      dat_q <= cam_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:        if (cont_i | arm_i) state_d = ST_WAIT_VS;
      ST_WAIT_VS:     if (vs_rise) state_d = ST_WAIT_VS_LOW;
      ST_WAIT_VS_LOW: if (vs_fall) state_d = ST_FRAME;
      ST_FRAME:       if (vs_rise) state_d = has_data_q ? ST_DONE : ST_WAIT_VS_LOW;
      ST_DONE:        state_d = cont_i ? ST_WAIT_VS_LOW : ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == ST_FRAME);
    frame_done_o = (state_q == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b0_q        <= '0;
      fmt_q       <= '0;
      phase_q     <= 1'b0;
      has_data_q  <= 1'b0;
      x_q         <= '0;
      line_q      <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fcnt_q      <= '0;
      line_ovf_q  <= 1'b0;
      frame_ovf_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (state_q == ST_DONE) fcnt_q <= fcnt_q + 1'b1;
      if (state_q == ST_IDLE && arm_i) begin
        line_ovf_q  <= 1'b0;
        frame_ovf_q <= 1'b0;
      end
      // Frame counters and format are re-primed every cycle until FRAME starts
      if (state_q == ST_WAIT_VS_LOW) begin
        fmt_q      <= fmt_i;
        phase_q    <= 1'b0;
        has_data_q <= 1'b0;
        x_q        <= '0;
        line_q     <= '0;
        addr_q     <= '0;
        base_q     <= '0;
      end
      if (pix_en) begin
        if (line_q >= L_MAX) begin
          frame_ovf_q <= 1'b1;
        end else begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            b0_q <= dat_q;
          end else if (x_q >= X_MAX) begin
            line_ovf_q <= 1'b1;
          end else begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= addr_q;
            wr_data_q  <= pix;
            addr_q     <= addr_q + 1'b1;
            x_q        <= x_q + 1'b1;
            has_data_q <= 1'b1;
          end
        end
      end
      if (state_q == ST_FRAME && hr_fall) begin
        phase_q <= 1'b0;
        x_q     <= '0;
        if (line_q < L_MAX) begin
          line_q <= line_q + 1'b1;
          base_q <= base_q + A_STEP;
          addr_q <= base_q + A_STEP;
        end
      end
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_cnt_o = fcnt_q;
  assign line_ovf_o  = line_ovf_q;
  assign frame_ovf_o = frame_ovf_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed + randomized bench for cam_frame_capture; expected writes come
// from a per-frame pixel model using channel arithmetic.
module tb_cam_frame_capture;

  localparam int W = 64, H = 6, AW = 9, FW = 2;

  logic clk = 1'b0;
  logic rst, vsync, href, cont, arm;
  logic [7:0] cam;
  logic [1:0] fmt;
  logic wr_en, busy, done, lovf, fovf;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [FW-1:0] fcnt;

  always #5 clk = ~clk;

  cam_frame_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FCNT_W(FW)) dut (
    .clk_i(clk), .rst_i(rst), .vsync_i(vsync), .href_i(href), .cam_data_i(cam),
    .fmt_i(fmt), .cont_i(cont), .arm_i(arm), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .busy_o(busy), .frame_done_o(done), .frame_cnt_o(fcnt),
    .line_ovf_o(lovf), .frame_ovf_o(fovf)
  );

  int checks = 0, errors = 0;
  int got_a[$], got_d[$], exp_a[$], exp_d[$];
  int done_n = 0, done0 = 0;
  bit m_cap, m_has, m_lovf, m_fovf;
  int m_line, m_fmt, m_fcnt;

  always @(negedge clk) begin
    if (wr_en) begin
      got_a.push_back(int'(wr_addr));
      got_d.push_back(int'(wr_data));
    end
    if (done) done_n++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Truncate each colour channel to its RGB332 share
  function automatic int conv(int f, int b0, int b1);
    int r, g, b;
    case (f)
      0: begin r = b0 >> 3; g = ((b0 & 7) << 3) | (b1 >> 5); b = b1 & 31;
               return ((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3); end
      1: begin r = (b0 >> 2) & 31; g = ((b0 & 3) << 3) | (b1 >> 5); b = b1 & 31;
               return ((r >> 2) << 5) | ((g >> 2) << 2) | (b >> 3); end
      2: begin r = b0 & 15; g = b1 >> 4; b = b1 & 15;
               return ((r >> 1) << 5) | ((g >> 1) << 2) | (b >> 2); end
      default: return b0;
    endcase
  endfunction

  task automatic frame_begin(bit cap);
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    done0 = done_n;
    vsync = 1'b0; tick(2);
    vsync = 1'b1; tick(4);
    vsync = 1'b0; tick(4);
    m_cap = cap; m_has = 0; m_line = 0; m_fmt = int'(fmt);
  endtask

  task automatic model_pix(int i, int b0, int b1);
    if (!m_cap) return;
    if (m_line >= H) m_fovf = 1;
    else if (i >= W) m_lovf = 1;
    else begin
      exp_a.push_back(m_line * W + i);
      exp_d.push_back(conv(m_fmt, b0, b1));
      m_has = 1;
    end
  endtask

  // b0f/b1f < 0 selects random bytes
  task automatic send_line(int npix, bit odd, int b0f, int b1f);
    int b0, b1;
    for (int i = 0; i < npix; i++) begin
      b0 = (b0f < 0) ? int'($urandom_range(255)) : b0f;
      b1 = (b1f < 0) ? int'($urandom_range(255)) : b1f;
      href = 1'b1; cam = 8'(b0); tick();
      cam = 8'(b1); tick();
      model_pix(i, b0, b1);
    end
    if (odd) begin
      href = 1'b1; cam = 8'($urandom_range(255)); tick();
      if (m_cap && m_line >= H) m_fovf = 1;
    end
    href = 1'b0; tick(3);
    if (m_cap) m_line++;
  endtask

  task automatic frame_end_check(string tag);
    bit exp_done;
    vsync = 1'b1; tick(5);
    exp_done = m_cap && m_has;
    if (exp_done) m_fcnt = (m_fcnt + 1) % (1 << FW);
    chk($sformatf("%s-nwr", tag), got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      chk($sformatf("%s-addr%0d", tag, i), got_a[i], exp_a[i]);
      chk($sformatf("%s-data%0d", tag, i), got_d[i], exp_d[i]);
    end
    chk($sformatf("%s-done", tag), done_n - done0, exp_done ? 1 : 0);
    chk($sformatf("%s-fcnt", tag), fcnt, m_fcnt);
    chk($sformatf("%s-lovf", tag), lovf, m_lovf);
    chk($sformatf("%s-fovf", tag), fovf, m_fovf);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; href = 1'b0; cam = '0; fmt = 2'b00; cont = 1'b0; arm = 1'b0;
    m_cap = 0; m_has = 0; m_lovf = 0; m_fovf = 0; m_line = 0; m_fmt = 0; m_fcnt = 0;
    tick(3);
    chk("rst-outs", {wr_en, busy, done, lovf, fovf}, 0);
    chk("rst-addr", wr_addr, 0);
    chk("rst-fcnt", fcnt, 0);
    rst = 1'b0; cont = 1'b1; tick(2);

    // 2x2 RGB565 frame of pure red
    frame_begin(1);
    send_line(2, 0, 'hF8, 'h00);
    chk("busy-mid", busy, 1);
    send_line(2, 0, 'hF8, 'h00);
    frame_end_check("2x2");
    chk("2x2-a2", got_a.size() > 2 ? got_a[2] : -1, W);
    chk("2x2-d0", got_d.size() > 0 ? got_d[0] : -1, 'hE0);
    chk("busy-after", busy, 0);

    // each format on the same byte pair
    for (int f = 0; f < 4; f++) begin
      fmt = 2'(f);
      frame_begin(1);
      send_line(1, 0, 'hA5, 'h3C);
      frame_end_check($sformatf("fmt%0d", f));
    end

    // random frames: odd trailing bytes, format changed mid-frame
    for (int k = 0; k < 3; k++) begin
      fmt = 2'($urandom_range(3));
      frame_begin(1);
      for (int l = 0; l < 3; l++) begin
        send_line(int'($urandom_range(1, 10)), 1'($urandom_range(1)), -1, -1);
        fmt = fmt + 2'd1;
      end
      frame_end_check($sformatf("rnd%0d", k));
    end

    // line and frame overflow
    fmt = 2'b11;
    frame_begin(1);
    send_line(W + 3, 0, -1, -1);
    frame_end_check("lovf");
    frame_begin(1);
    for (int l = 0; l < H + 2; l++) send_line(W, 0, -1, -1);
    cont = 1'b0;
    frame_end_check("fovf");
    chk("fovf-last", got_a.size() > 0 ? got_a[got_a.size()-1] : -1, W * H - 1);

    // single shot: ARM clears flags, only the first of three frames stored
    arm = 1'b1; tick();
    arm = 1'b0; m_lovf = 0; m_fovf = 0; tick();
    chk("arm-clr", {lovf, fovf}, 0);
    for (int k = 0; k < 3; k++) begin
      frame_begin(k == 0);
      send_line(3, 0, -1, -1);
      frame_end_check($sformatf("ss%0d", k));
      chk($sformatf("ss%0d-busy", k), busy, 0);
    end
    cont = 1'b1; tick(2);
    for (int k = 0; k < 3; k++) begin
      frame_begin(1);
      send_line(4, 0, -1, -1);
      send_line(2, 1, -1, -1);
      frame_end_check($sformatf("ct%0d", k));
    end

    // reset mid-line at pixel 50
    frame_begin(0);
    href = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cam = 8'($urandom_range(255)); tick();
      cam = 8'($urandom_range(255)); tick();
    end
    rst = 1'b1; tick();
    chk("mrst-outs", {wr_en, busy, done, lovf, fovf}, 0);
    chk("mrst-addr", wr_addr, 0);
    chk("mrst-data", wr_data, 0);
    chk("mrst-fcnt", fcnt, 0);
    rst = 1'b0; href = 1'b0; m_fcnt = 0; m_lovf = 0; m_fovf = 0;
    vsync = 1'b1; tick(4);
    frame_begin(1);
    send_line(3, 0, -1, -1);
    frame_end_check("post-rst");

    // frame without lines: no done, no count
    frame_begin(1);
    frame_end_check("empty");

    // truncated frame: VSYNC rises with HREF still high, mid-pixel
    frame_begin(1);
    href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int b0, b1;
      b0 = int'($urandom_range(255)); b1 = int'($urandom_range(255));
      cam = 8'(b0); tick();
      cam = 8'(b1); tick();
      model_pix(i, b0, b1);
    end
    cam = 8'h5A; tick();
    vsync = 1'b1; cam = 8'hC3; tick(4);
    href = 1'b0; tick(2);
    frame_end_check("trunc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
